bch_encoder_serial: RTL and testbench
=====================================

Name: bch_encoder_serial

Overview:
Bit-serial systematic BCH encoder. It is the transmit-side counterpart of the Euclidean BCH decoder, with the same field and code: GF(2^13), t=16, 208 parity bits.
- Accepts K message bits through a valid/ready stream and forwards them unchanged.
- Then appends R parity bits, computed by LFSR division of m(x)·x^R by g(x).
- Sits between the framing logic and the channel/modulator interface.

Parameters:
K, 7983, message bits per codeword (n = K+R ≤ 8191).
R, 208, parity bits = degree of g(x) = M·T.
GEN_POLY, g(x) for p(x)=x^13+x^4+x^3+x+1 with T=16 (R+1 bits; bit R and bit 0 = 1), generator polynomial coefficients, bit i = coeff of x^i.
CNT_W, 13, counter width; must satisfy 2^CNT_W > max(K,R).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  message bit valid.
in_ready  out  1  encoder accepts in_data this cycle.
in_data  in  1  message bit, highest-degree coefficient first.
in_sop  in  1  marks first message bit of a codeword.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
out_data  out  1  codeword bit: message, then parity MSB (x^(R-1)) first.
out_sop  out  1  first codeword bit.
out_eop  out  1  last parity bit.
busy  out  1  state != IDLE or out_valid=1.
sop_err  out  1  one-cycle pulse: in_sop seen mid-message (frame restarted).

Behaviour:
- Reset (async assert, sync-deassert at the system level):
  - Outputs: out_valid=0, out_data=0, out_sop=0, out_eop=0, sop_err=0.
  - Internal: state=IDLE, lfsr=0, counters=0.
- Output stage:
  - Single register. A new bit may load when !out_valid || out_ready ("load_ok").
  - Input-to-output latency is 1 cycle. Full throughput is 1 bit/clk when out_ready is held high.
  - out_* are held stable while out_valid && !out_ready.
- in_ready = load_ok && (state==IDLE || state==MSG). It is 0 in PAR.
- FSM states and transitions:
  - IDLE:
    - Accept only with in_valid && in_sop; bits without in_sop are accepted and dropped.
    - On a valid sop accept: lfsr=0, then apply the update below, msg_cnt=1, emit the bit with out_sop=1, go to MSG.
    - If K==1, go directly to PAR.
  - MSG:
    - On accept: fb = in_data ^ lfsr[R-1]; lfsr = (lfsr<<1) ^ (fb ? GEN_POLY[R-1:0] : 0); forward in_data; msg_cnt++.
    - After the K-th accepted bit, go to PAR with par_cnt=0.
    - in_sop=1 on an accepted bit in MSG: pulse sop_err, discard the partial frame, restart as in IDLE with this bit as the first bit (out_sop=1).
  - PAR:
    - When load_ok: out_data = lfsr[R-1], lfsr = lfsr<<1 (zero fill, no feedback), par_cnt++.
    - On par_cnt == R-1, set out_eop=1 and go to IDLE.
    - No input is consumed.
- Back-to-back codewords: in_ready rises in the same cycle the last parity bit loads into the output register. There are no bubbles between codewords if out_ready=1.
- The LFSR is cleared only at sop; it is not cleared on eop.
- Reset mid-frame: everything returns to reset values immediately; the partial codeword is lost and no eop is emitted.
- Simultaneous in_valid with out stalled: the bit is not accepted, and the LFSR and counters hold.

Test Plan:
- Hamming override (K=4, R=3, GEN_POLY=4'b1011), message 1,0,0,0, out_ready=1 → out_data 1,0,0,0,1,0,1; sop on bit 0; eop on bit 6; 7 consecutive valid cycles.
- Same override, message 0,0,0,1 → 0,0,0,1,0,1,1. Then an immediate second frame 1,0,0,0 → no gap cycle, parity 1,0,1.
- Default parameters, all-zero 7983-bit message → 208 zero parity bits. A single 1 at the last message position → parity equals GEN_POLY[207:0] MSB first.
- Random out_ready (50% duty), random message, default parameters → codeword divisible by g(x) (reference model); no bit lost or duplicated; out_* stable during stalls.
- Hamming override, in_sop reasserted on message bit 2 → sop_err pulses once; the new frame's codeword is correct and the old frame never gets eop.
- rst_n asserted during PAR, then a fresh frame 1,0,0,0 → outputs zero during reset; the next codeword is 1,0,0,0,1,0,1 with no stale parity.

Source files
------------

// File: rtl/bch_encoder_serial_if.sv
// Stream bundle for the serial BCH encoder: message bits in, codeword bits out.
// master = framing/channel side, slave = encoder side.
interface bch_encoder_serial_if;
    logic in_valid;
    logic in_ready;
    logic in_data;
    logic in_sop;
    logic out_valid;
    logic out_ready;
    logic out_data;
    logic out_sop;
    logic out_eop;

    modport master (
        output in_valid, in_data, in_sop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_data, in_sop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/bch_encoder_serial.sv
// Bit-serial systematic BCH encoder (default GF(2^13), t=16, R=208).
// Ports: clk, rst_n (async low), bus (slave stream: message in, codeword out),
// busy (frame in flight or output pending), sop_err (in_sop seen mid-message).
package bch_encoder_serial_pkg;
    localparam int GM = 13;
    localparam int GT = 16;
    localparam int GR = GM * GT;
    localparam logic [GM:0] PRIM = 14'h201B;

    function automatic logic [GM-1:0] gf_mul(
        input logic [GM-1:0] a,
        input logic [GM-1:0] b
    );
        logic [GM:0] r;
        r = '0;
        for (int i = GM - 1; i >= 0; i--) begin
            r = {r[GM-1:0], 1'b0};
            if (r[GM]) r = r ^ PRIM;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[GM-1:0];
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3 .. alpha^(2T-1).
    // Each minimal polynomial is built from its 13 conjugates (repeated squaring).
    function automatic logic [GR:0] gen_poly();
        logic [GR:0]          g;
        logic [GR:0]          acc;
        logic [(GM+1)*GM-1:0] mp;
        logic [GM-1:0]        beta;
        logic [GM-1:0]        b;
        logic [GM-1:0]        alpha;
        alpha = GM'(2);
        g     = '0;
        g[0]  = 1'b1;
        beta  = alpha;
        for (int i = 1; i < 2 * GT; i += 2) begin
            mp          = '0;
            mp[GM-1:0]  = GM'(1);
            b           = beta;
            for (int j = 0; j < GM; j++) begin
                for (int k = GM; k > 0; k--) begin
                    mp[k*GM +: GM] = gf_mul(mp[k*GM +: GM], b)
                                   ^ mp[(k-1)*GM +: GM];
                end
                mp[0 +: GM] = gf_mul(mp[0 +: GM], b);
                b = gf_mul(b, b);
            end
            acc = '0;
            for (int k = 0; k <= GM; k++) begin
                if (mp[k*GM]) acc = acc ^ (g << k);
            end
            g    = acc;
            beta = gf_mul(gf_mul(beta, alpha), alpha);
        end
        return g;
    endfunction
endpackage

module bch_encoder_serial
    import bch_encoder_serial_pkg::*;
#(
    parameter int         K        = 7983,
    parameter int         R        = GR,
    parameter logic [R:0] GEN_POLY = gen_poly(),
    parameter int         CNT_W    = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bch_encoder_serial_if.slave        bus,
    output logic                       busy,
    output logic                       sop_err
);
    typedef enum logic [1:0] {IDLE, MSG, PAR} state_e;

    localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(K);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R - 1);
    localparam logic [R-1:0]     G_LOW  = GEN_POLY[R-1:0];

    state_e           state_q, state_d;
    logic [R-1:0]     lfsr_q, lfsr_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_data_q, out_data_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic             sop_err_q, sop_err_d;

    logic load_ok;
    logic in_rdy;
    logic accept;
    logic fb;

    assign load_ok = !out_valid_q || bus.out_ready;
    assign in_rdy  = load_ok && (state_q != PAR);
    assign accept  = bus.in_valid && in_rdy;
    assign fb      = bus.in_data ^ lfsr_q[R-1];

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        msg_cnt_d   = msg_cnt_q;
        par_cnt_d   = par_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        sop_err_d   = 1'b0;
        // Current output bit is consumed (or absent); clear unless reloaded.
        if (load_ok) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
        end
        unique case (state_q)
            IDLE, MSG: begin
                // In IDLE a bit without sop is accepted and dropped.
                if (accept && (bus.in_sop || state_q == MSG)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data;
                    out_sop_d   = bus.in_sop;
                    lfsr_d      = (lfsr_q << 1) ^ (fb ? G_LOW : '0);
                    msg_cnt_d   = msg_cnt_q + CNT_W'(1);
                    if (bus.in_sop) begin
                        // Frame (re)start: division restarts from a zero remainder.
                        sop_err_d = (state_q == MSG);
                        lfsr_d    = bus.in_data ? G_LOW : '0;
                        msg_cnt_d = CNT_W'(1);
                    end
                    if (msg_cnt_d == K_CNT) begin
                        state_d   = PAR;
                        par_cnt_d = '0;
                    end else begin
                        state_d   = MSG;
                    end
                end
            end
            PAR: begin
                if (load_ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = lfsr_q[R-1];
                    lfsr_d      = lfsr_q << 1;
                    par_cnt_d   = par_cnt_q + CNT_W'(1);
                    if (par_cnt_q == R_LAST) begin
                        out_eop_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            msg_cnt_q   <= '0;
            par_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            sop_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            msg_cnt_q   <= msg_cnt_d;
            par_cnt_q   <= par_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            sop_err_q   <= sop_err_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign busy          = (state_q != IDLE) || out_valid_q;
    assign sop_err       = sop_err_q;
endmodule

// File: tb/tb_bch_encoder_serial.sv
// Scoreboard bench for bch_encoder_serial: a (7,4) Hamming instance and a
// default BCH instance, checked against polynomial long division by g(x).
module tb_bch_encoder_serial;
    localparam int HK  = 4;
    localparam int HR  = 3;
    localparam int DK  = 7983;
    localparam int DR  = 208;
    localparam int TMO = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bch_encoder_serial_if bh ();
    bch_encoder_serial_if bd ();
    logic busy_h, sop_err_h, busy_d, sop_err_d;

    bch_encoder_serial #(
        .K(HK), .R(HR), .GEN_POLY(4'b1011), .CNT_W(3)
    ) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(bh), .busy(busy_h), .sop_err(sop_err_h)
    );

    bch_encoder_serial dut_d (
        .clk(clk), .rst_n(rst_n), .bus(bd), .busy(busy_d), .sop_err(sop_err_d)
    );

    int         checks = 0;
    int         errors = 0;
    logic [2:0] expq [0:1][$];
    int         runs_h [$];
    int         run [0:1];
    bit         stall [0:1];
    logic [2:0] last [0:1];
    int         serrcnt [0:1];
    bit         rand_rdy [0:1];
    logic [DR:0] g_def;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // GF(2^13) arithmetic, p(x) = x^13 + x^4 + x^3 + x + 1.
    function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] r;
        logic [12:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) r = r ^ x;
            x = x[12] ? ({x[11:0], 1'b0} ^ 13'h001B) : {x[11:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [12:0] apow(input int e);
        logic [12:0] r;
        logic [12:0] base;
        r    = 13'd1;
        base = 13'd2;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        return r;
    endfunction

    // g(x) as the product of (x - beta) over all 208 required roots.
    task automatic build_g();
        logic [12:0] c [0:DR];
        logic [12:0] beta;
        int deg;
        deg = 0;
        for (int k = 0; k <= DR; k++) c[k] = '0;
        c[0] = 13'd1;
        for (int i = 1; i < 32; i += 2) begin
            for (int j = 0; j < 13; j++) begin
                beta = apow((i << j) % 8191);
                for (int k = deg + 1; k > 0; k--) c[k] = c[k-1] ^ gmul(c[k], beta);
                c[0] = gmul(c[0], beta);
                deg++;
            end
        end
        for (int k = 0; k <= DR; k++) begin
            if (c[k][12:1] != 0) begin
                $display("FAIL g_build: coefficient %0d not binary", k);
                $fatal(1, "g(x) construction");
            end
            g_def[k] = c[k][0];
        end
    endtask

    // Expected codeword: message, then remainder of m(x)*x^R mod g(x).
    task automatic push_cw(input int i, input bit msg[$]);
        bit w[$];
        int k;
        int r;
        logic [DR:0] g;
        k = msg.size();
        r = (i == 1) ? HR : DR;
        g = (i == 1) ? {{(DR - HR){1'b0}}, 4'b1011} : g_def;
        w = msg;
        for (int n = 0; n < r; n++) w.push_back(1'b0);
        for (int a = 0; a < k; a++) begin
            if (w[a]) begin
                for (int b = 0; b <= r; b++) w[a+b] = w[a+b] ^ g[r-b];
            end
        end
        for (int a = 0; a < k + r; a++) begin
            expq[i].push_back({(a < k) ? msg[a] : w[a], a == 0, a == k + r - 1});
        end
    endtask

    task automatic push_part(input int i, input bit msg[$]);
        for (int a = 0; a < msg.size(); a++) expq[i].push_back({msg[a], a == 0, 1'b0});
    endtask

    task automatic drive(input int i, input bit v, input bit d, input bit s);
        if (i == 1) begin
            bh.in_valid = v; bh.in_data = d; bh.in_sop = s;
        end else begin
            bd.in_valid = v; bd.in_data = d; bd.in_sop = s;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int i, input bit d, input bit s);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        drive(i, 1'b1, d, s);
        while (!acc) begin
            @(negedge clk);
            acc = (i == 1) ? bh.in_ready : bd.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > TMO) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_msg(input int i, input bit msg[$]);
        for (int a = 0; a < msg.size(); a++) send(i, msg[a], a == 0);
    endtask

    function automatic void vec4(input logic [3:0] v, output bit q[$]);
        q = {};
        for (int a = 3; a >= 0; a--) q.push_back(v[a]);
    endfunction

    task automatic drain(input int i);
        int n;
        n = 0;
        while ((expq[i].size() != 0 || ((i == 1) ? busy_h : busy_d)) && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check((i == 1) ? "h_drain" : "d_drain", expq[i].size(), 0);
    endtask

    task automatic mon(input int i, input logic v, input logic rdy, input logic dat,
                       input logic sop, input logic eop, input logic serr, input logic bsy);
        logic [2:0] cur;
        logic [2:0] e;
        string p;
        int x;
        p = (i == 1) ? "h" : "d";
        cur = {dat, sop, eop};
        if (!rst_n) begin
            check({p, "_reset_outputs"}, int'({v, dat, sop, eop, serr, bsy}), 0);
            stall[i] = 1'b0;
            run[i] = 0;
            return;
        end
        if (stall[i]) check({p, "_stall_hold"}, int'({v, cur}), int'({1'b1, last[i]}));
        if (serr) serrcnt[i]++;
        if (v && rdy) begin
            run[i]++;
            if (expq[i].size() == 0) begin
                check({p, "_unexpected_bit"}, int'(cur), -1);
            end else begin
                e = expq[i].pop_front();
                check({p, "_bit{data,sop,eop}"}, int'(cur), int'(e));
            end
            if (eop && i == 1 && runs_h.size() != 0) begin
                x = runs_h.pop_front();
                check("h_consecutive_valid", run[i], x);
            end
        end else if (!v) begin
            run[i] = 0;
        end
        stall[i] = v && !rdy;
        last[i] = cur;
    endtask

    initial begin
        bh.out_ready = 1'b1;
        bd.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bh.out_ready = rand_rdy[1] ? 1'($urandom_range(0, 1)) : 1'b1;
            bd.out_ready = rand_rdy[0] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; stall[i] = 1'b0; last[i] = '0; serrcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            mon(1, bh.out_valid, bh.out_ready, bh.out_data, bh.out_sop, bh.out_eop,
                sop_err_h, busy_h);
            mon(0, bd.out_valid, bd.out_ready, bd.out_data, bd.out_sop, bd.out_eop,
                sop_err_d, busy_d);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m[$];
        bit m2[$];
        rand_rdy[0] = 1'b0;
        rand_rdy[1] = 1'b0;
        idle(0);
        idle(1);
        build_g();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hamming 1000 -> 1000101, seven consecutive valid bits.
        vec4(4'b1000, m);
        push_cw(1, m);
        runs_h.push_back(7);
        send_msg(1, m);
        idle(1);
        drain(1);

        // Bits without sop in IDLE are dropped; then 0001 and 1000 back to back.
        send(1, 1'b1, 1'b0);
        send(1, 1'b1, 1'b0);
        vec4(4'b0001, m);
        vec4(4'b1000, m2);
        push_cw(1, m);
        push_cw(1, m2);
        runs_h.push_back(7);
        runs_h.push_back(14);
        send_msg(1, m);
        send_msg(1, m2);
        idle(1);
        drain(1);

        // sop reasserted on message bit 2: frame restarts without a gap.
        vec4(4'b1100, m);
        m = m[0:1];
        push_part(1, m);
        vec4(4'b1010, m2);
        push_cw(1, m2);
        runs_h.push_back(9);
        send_msg(1, m);
        send_msg(1, m2);
        idle(1);
        drain(1);

        // Reset while emitting parity; the partial codeword is discarded.
        vec4(4'b0110, m);
        push_cw(1, m);
        send_msg(1, m);
        idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        expq[1].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec4(4'b1000, m);
        push_cw(1, m);
        runs_h.push_back(7);
        send_msg(1, m);
        idle(1);
        drain(1);

        // Default code: all-zero message, then a single 1 in the last position.
        m = {};
        for (int a = 0; a < DK; a++) m.push_back(1'b0);
        push_cw(0, m);
        send_msg(0, m);
        m[DK-1] = 1'b1;
        push_cw(0, m);
        send_msg(0, m);
        idle(0);
        drain(0);

        // Random message with 50% output stalls on the default code.
        rand_rdy[0] = 1'b1;
        m = {};
        for (int a = 0; a < DK; a++) m.push_back(1'($urandom_range(0, 1)));
        push_cw(0, m);
        send_msg(0, m);
        idle(0);
        drain(0);
        rand_rdy[0] = 1'b0;

        // Random Hamming frames under stalls.
        rand_rdy[1] = 1'b1;
        for (int f = 0; f < 12; f++) begin
            vec4(4'($urandom_range(0, 15)), m);
            push_cw(1, m);
            send_msg(1, m);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        drain(1);
        rand_rdy[1] = 1'b0;

        check("h_sop_err_pulses", serrcnt[1], 1);
        check("d_sop_err_pulses", serrcnt[0], 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
